// File: rtl/alu_issue_ctrl.sv
// Control unit of the 8-bit core: fetch, ALU issue/commit, LOAD/STORE sequencing; ALU op = fetch+1 cycles, memory op = fetch+1+ack cycles.
// Waits indefinitely on instr_valid / dmem_ack; ALU_ISSUE_CTRL_PERF_EN adds a saturating retired_cnt output.
module alu_issue_ctrl #(
  parameter int unsigned     PC_W       = 8,
  parameter logic [PC_W-1:0] START_PC   = '0,
  parameter logic [8:0]      HALT_INSTR = 9'h17F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [8:0]      instr_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  output logic [7:0]      dmem_wdata,
  input  logic            dmem_ack,
  input  logic [7:0]      dmem_rdata,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero,
`ifdef ALU_ISSUE_CTRL_PERF_EN
  output logic [15:0]     retired_cnt,
`endif
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] fa;
    logic [2:0] fb;
  } instr_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_SHF   = 3'b111;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  instr_t          ir_q;
  logic [7:0]      regs_q [8];
  logic            eq_q;

  logic [7:0]      rfa;
  logic [7:0]      rfb;
  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            wr_alu;
  logic            jump_taken;

  assign rfa        = regs_q[ir_q.fa];
  assign rfb        = regs_q[ir_q.fb];
  assign pc_inc     = pc_q + PC_W'(1);
  assign is_load    = (ir_q.op == OP_LOAD);
  assign is_store   = (ir_q.op == OP_STORE);
  assign is_mem     = is_load || is_store;
  assign wr_alu     = (ir_q.op == OP_ADD) || (ir_q.op == OP_ADDI) ||
                      (ir_q.op == OP_XOR) || (ir_q.op == OP_SHF);
  assign jump_taken = (ir_q.op == OP_JUMP) && eq_q;

  assign instr_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) state_d = (instr_data == HALT_INSTR) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = is_mem ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_req  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 8'h00;
    dmem_wdata = 8'h00;
    alu_op     = 3'b000;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        busy      = 1'b1;
      end
      S_EXEC: begin
        busy   = 1'b1;
        alu_op = ir_q.op;
        case (ir_q.op)
          OP_ADDI, OP_SHF: begin
            alu_a = rfa;
            alu_b = {5'b0, ir_q.fb};
          end
          // Memory ops present address/data on the ALU ports as well; result unused.
          OP_LOAD, OP_STORE: begin
            alu_a = rfb;
            alu_b = rfa;
          end
          OP_JUMP: begin
            alu_a = rfa;
            alu_b = 8'h00;
          end
          default: begin
            alu_a = rfa;
            alu_b = rfb;
          end
        endcase
      end
      S_MEM: begin
        busy       = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        dmem_addr  = rfb;
        dmem_wdata = rfa;
      end
      S_HALT: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural state; the halt word is captured into ir but never executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= START_PC;
      ir_q <= '0;
      eq_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) pc_q <= START_PC;
        end
        S_FETCH: begin
          if (instr_valid) ir_q <= instr_data;
        end
        S_EXEC: begin
          if (wr_alu) regs_q[ir_q.fa] <= alu_result;
          if (ir_q.op == OP_CMP) eq_q <= alu_zero;
          if (jump_taken) begin
            pc_q <= PC_W'(alu_result);
          end else if (!is_mem) begin
            pc_q <= pc_inc;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_load) regs_q[ir_q.fa] <= dmem_rdata;
            pc_q <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic retire;

  assign retire = ((state_q == S_EXEC) && !is_mem) || ((state_q == S_MEM) && dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= 16'h0000;
    end else if (retire && (retired_cnt != 16'hFFFF)) begin
      retired_cnt <= retired_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of single-op programs plus hand-written multi-cycle sequences.
module tb_alu_issue_ctrl;

  localparam logic [8:0] HALT = 9'h17F;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic [8:0]  instr_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack   = 1'b0;
  logic [7:0]  dmem_rdata = 8'h00;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        busy;
  logic        done;
`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic [15:0] retired_cnt;
`endif

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
`ifdef ALU_ISSUE_CTRL_PERF_EN
    .retired_cnt (retired_cnt),
`endif
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Instruction memory answers in the same cycle unless ihold stalls it.
  logic [8:0] imem [256];
  logic [7:0] dmem [256];
  logic       ihold = 1'b0;
  int         ack_cycles = 1;

  assign instr_valid = instr_req & ~ihold;
  assign instr_data  = imem[instr_addr];

  // Reference ALU: add for add/addi/jump/mem, xor, subtract for compare, left shift.
  always_comb begin
    case (alu_op)
      3'b010:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = alu_a << alu_b[2:0];
      default: alu_result = alu_a + alu_b;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  // Data memory responder: acks in the ack_cycles-th request cycle and logs each access.
  int         mcnt = 0;
  logic [7:0] m_addr0;
  logic [7:0] m_wdata0;
  logic       m_we0;
  bit         m_stable;
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];
  logic       log_we [$];
  int         log_len [$];
  bit         log_stable [$];

  always @(negedge clk) begin
    if (dmem_req) begin
      if (mcnt == 0) begin
        m_addr0  = dmem_addr;
        m_wdata0 = dmem_wdata;
        m_we0    = dmem_we;
        m_stable = 1'b1;
      end else if (dmem_addr != m_addr0 || dmem_wdata != m_wdata0 || dmem_we != m_we0) begin
        m_stable = 1'b0;
      end
      mcnt++;
      if (mcnt >= ack_cycles) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem[dmem_addr];
        log_addr.push_back(dmem_addr);
        log_data.push_back(dmem_we ? dmem_wdata : dmem[dmem_addr]);
        log_we.push_back(dmem_we);
        log_len.push_back(mcnt);
        log_stable.push_back(m_stable);
        mcnt = 0;
      end else begin
        dmem_ack = 1'b0;
      end
    end else begin
      dmem_ack = 1'b0;
      mcnt     = 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int fa, input int fb);
    return {op[2:0], fa[2:0], fb[2:0]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_to_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_to_done: done still 0 after %0d cycles", cyc);
    end
  endtask

  task automatic wait_exec_at(input logic [7:0] pc, input int max);
    int c;
    c = 0;
    while (!(busy && !instr_req && !dmem_req && instr_addr == pc) && c < max) begin
      @(posedge clk); #1;
      c++;
    end
    check("exec_reached", 32'(busy && !instr_req && !dmem_req && instr_addr == pc), 1);
  endtask

  typedef struct {
    int         op;
    int         fa;
    int         fb;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0;

    vecs[0] = '{0, 1, 2, 8'h30, 8'h25, 8'h55};
    vecs[1] = '{0, 3, 4, 8'hF0, 8'h20, 8'h10};
    vecs[2] = '{1, 1, 5, 8'h03, 8'h00, 8'h08};
    vecs[3] = '{2, 2, 3, 8'hF0, 8'h3C, 8'hCC};
    vecs[4] = '{2, 1, 1, 8'h5A, 8'h5A, 8'h00};
    vecs[5] = '{7, 5, 1, 8'h81, 8'h00, 8'h02};
    vecs[6] = '{7, 4, 3, 8'h0F, 8'h00, 8'h78};
    vecs[7] = '{1, 2, 6, 8'hFE, 8'h00, 8'h04};

    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

    // Reset state
    @(posedge clk); #1;
    check("rst_instr_req", 32'(instr_req), 0);
    check("rst_instr_addr", 32'(instr_addr), 0);
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 0);
    check("rst_busy_done", 32'({busy, done}), 0);
    rst_n = 1'b1;

    // ADDI R1,5 / ADDI R1,3 / HALT
    imem[0] = enc(1, 1, 5);
    imem[1] = enc(1, 1, 3);
    pulse_start();
    check("t1_fetch_busy", 32'({busy, instr_req}), 'h3);
    run_to_done(50, cyc);
    check("t1_cycles", 32'(cyc), 5);
    check("t1_halt_pc", 32'(instr_addr), 2);
    check("t1_halt_busy", 32'(busy), 0);

    // Registers survive start from HALT: store R1 to [R0]
    clear_imem();
    imem[0] = enc(4, 1, 0);
    n0 = log_addr.size();
    pulse_start();
    run_to_done(50, cyc);
    check("t1_log_count", 32'(log_addr.size()), 32'(n0 + 1));
    if (log_addr.size() > n0) begin
      check("t1_r1_value", 32'(log_data[n0]), 'h08);
      check("t1_r1_we", 32'(log_we[n0]), 1);
    end

    // Table: load operands, run one op, store result to [1]
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_imem();
      dmem[0] = vecs[i].va;
      dmem[1] = vecs[i].vb;
      imem[0] = enc(3, vecs[i].fa, 0);
      imem[1] = enc(1, 7, 1);
      imem[2] = enc(3, vecs[i].fb, 7);
      imem[3] = enc(vecs[i].op, vecs[i].fa, vecs[i].fb);
      imem[4] = enc(4, vecs[i].fa, 7);
      n0 = log_addr.size();
      pulse_start();
      run_to_done(100, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 14);
      check($sformatf("vec%0d_count", i), 32'(log_addr.size()), 32'(n0 + 3));
      if (log_addr.size() == n0 + 3) begin
        check($sformatf("vec%0d_addr", i), 32'(log_addr[n0 + 2]), 1);
        check($sformatf("vec%0d_result", i), 32'(log_data[n0 + 2]), 32'(vecs[i].exp));
      end
    end

    // Taken jump: R3=0x10, CMP R2,R2
    do_reset();
    clear_imem();
    dmem[0] = 8'h10;
    imem[0] = enc(3, 3, 0);
    imem[1] = enc(1, 2, 7);
    imem[2] = enc(6, 2, 2);
    imem[3] = enc(5, 3, 0);
    pulse_start();
    wait_exec_at(8'h03, 50);
    check("jmp_alu_op", 32'(alu_op), 5);
    check("jmp_alu_a", 32'(alu_a), 'h10);
    check("jmp_alu_b", 32'(alu_b), 0);
    @(posedge clk); #1;
    check("jmp_taken_pc", 32'({instr_req, instr_addr}), 'h110);
    run_to_done(20, cyc);
    check("jmp_taken_halt_pc", 32'(instr_addr), 'h10);

    // Not taken: CMP R2,R0
    do_reset();
    imem[2] = enc(6, 2, 0);
    pulse_start();
    wait_exec_at(8'h03, 50);
    @(posedge clk); #1;
    check("jmp_nt_pc", 32'({instr_req, instr_addr}), 'h104);

    // STORE R1->[R2] with 3-cycle ack, then LOAD R4<-[R2] returns 0xA5
    do_reset();
    clear_imem();
    ack_cycles = 3;
    dmem[5] = 8'hA5;
    imem[0] = enc(1, 1, 6);
    imem[1] = enc(1, 2, 5);
    imem[2] = enc(4, 1, 2);
    imem[3] = enc(3, 4, 2);
    imem[4] = enc(4, 4, 0);
    n0 = log_addr.size();
    pulse_start();
    run_to_done(100, cyc);
    check("mem_cycles", 32'(cyc), 20);
    check("mem_count", 32'(log_addr.size()), 32'(n0 + 3));
    if (log_addr.size() == n0 + 3) begin
      check("st_we_addr_data", 32'({log_we[n0], log_addr[n0], log_data[n0]}), 'h10506);
      check("st_req_cycles", 32'(log_len[n0]), 3);
      check("st_stable", 32'(log_stable[n0]), 1);
      check("ld_we_addr", 32'({log_we[n0 + 1], log_addr[n0 + 1]}), 'h005);
      check("ld_req_cycles", 32'(log_len[n0 + 1]), 3);
      check("ld_r4_value", 32'({log_addr[n0 + 2], log_data[n0 + 2]}), 'h00A5);
    end
    ack_cycles = 1;

    // PC wrap: jump to 0xFF, execute ADD there, next fetch at 0
    do_reset();
    clear_imem();
    dmem[0] = 8'hFF;
    imem[0]   = enc(3, 3, 0);
    imem[1]   = enc(6, 0, 0);
    imem[2]   = enc(5, 3, 0);
    imem[255] = enc(0, 1, 1);
    pulse_start();
    wait_exec_at(8'hFF, 50);
    check("wrap_alu_op", 32'(alu_op), 0);
    @(posedge clk); #1;
    check("wrap_pc", 32'({instr_req, instr_addr}), 'h100);

    // Reset while a store is pending
    do_reset();
    clear_imem();
    ack_cycles = 20;
    imem[0] = enc(1, 1, 7);
    imem[1] = enc(4, 1, 0);
    n0 = log_addr.size();
    pulse_start();
    cyc = 0;
    while (!dmem_req && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_req_seen", 32'(dmem_req), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_req_drop", 32'(dmem_req), 0);
    check("abort_state", 32'({busy, done, instr_req, instr_addr}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ack_cycles = 1;
    clear_imem();
    imem[0] = enc(4, 1, 0);
    pulse_start();
    run_to_done(50, cyc);
    check("abort_log_count", 32'(log_addr.size()), 32'(n0 + 1));
    if (log_addr.size() == n0 + 1) begin
      check("abort_r1_cleared", 32'(log_data[n0]), 0);
    end

    // start during a stalled FETCH is ignored
    do_reset();
    clear_imem();
    imem[0] = enc(1, 1, 1);
    pulse_start();
    @(posedge clk); #1 ihold = 1'b1;
    @(posedge clk); #1;
    check("ign_fetch_pc", 32'({instr_req, instr_addr}), 'h101);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("ign_start_pc", 32'({instr_req, busy, instr_addr}), 'h301);
    ihold = 1'b0;
    run_to_done(20, cyc);
    check("ign_halt_pc", 32'(instr_addr), 1);

`ifdef ALU_ISSUE_CTRL_PERF_EN
    do_reset();
    check("perf_reset", 32'(retired_cnt), 0);
    clear_imem();
    imem[0] = enc(1, 1, 1);
    imem[1] = enc(1, 1, 1);
    imem[2] = enc(2, 2, 1);
    pulse_start();
    run_to_done(50, cyc);
    check("perf_three", 32'(retired_cnt), 3);
    pulse_start();
    run_to_done(50, cyc);
    check("perf_not_cleared", 32'(retired_cnt), 6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
